mux_rr_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking. It is the sequential successor of the gate-level 2:1 mux: it selects one of N streaming sources, either by an external select (fixed mode) or by a fair round-robin arbiter, and holds the winner in a one-entry output register. It sits between several producers and a single consumer, and sustains one transfer per cycle.

---
 rtl/mux_rr_n.sv | 102 ++++++++++
 tb/tb_mux_rr_n.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// N-channel, W-bit registered multiplexer with valid/ready handshaking.
// The winner comes from either an external select or a round-robin arbiter, and is held in a one-entry output register.
module mux_rr_n #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mode_i,
    input  logic [SELW-1:0] sel_i,
    input  logic [N-1:0]    in_valid_i,
    input  logic [N*W-1:0]  in_data_i,
    output logic [N-1:0]    in_ready_o,
    output logic            out_valid_o,
    output logic [W-1:0]    out_data_o,
    output logic [SELW-1:0] out_ch_o,
    input  logic            out_ready_i
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic [W-1:0]    grant_data;
    logic [SELW-1:0] ptr_nxt;
    logic            load_en;
    logic            xfer;

    // Round-robin search runs in two passes: ptr..N-1, then 0..ptr-1.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        ptr_nxt    = ptr_q;
        if (!mode_i) begin
            for (int i = 0; i < N; i++) begin
                if (sel_i == SELW'(i) && in_valid_i[i]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SELW'(i);
                    grant_data = in_data_i[i*W +: W];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!grant_vld && i >= int'(ptr_q) && in_valid_i[i]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SELW'(i);
                    grant_data = in_data_i[i*W +: W];
                    ptr_nxt    = (i == N-1) ? '0 : SELW'(i+1);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!grant_vld && i < int'(ptr_q) && in_valid_i[i]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SELW'(i);
                    grant_data = in_data_i[i*W +: W];
                    ptr_nxt    = (i == N-1) ? '0 : SELW'(i+1);
                end
            end
        end
    end

    assign load_en = !out_valid_q || out_ready_i;
    assign xfer    = load_en && grant_vld && !rst_i;

    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            in_ready_o[i] = xfer && (grant_idx == SELW'(i));
        end
    end

    always_comb begin
        out_valid_d = load_en ? grant_vld : out_valid_q;
        out_data_d  = xfer ? grant_data : out_data_q;
        out_ch_d    = xfer ? grant_idx : out_ch_q;
        ptr_d       = (xfer && mode_i) ? ptr_nxt : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n: a 4-channel instance and a 3-channel instance, driven with directed vectors.
module tb_mux_rr_n;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_mode, a_oready, a_ovalid;
    logic [1:0]  a_sel, a_och;
    logic [3:0]  a_valid, a_ready;
    logic [31:0] a_data;
    logic [7:0]  a_odata;

    logic        b_mode, b_oready, b_ovalid;
    logic [1:0]  b_sel, b_och;
    logic [2:0]  b_valid, b_ready;
    logic [23:0] b_data;
    logic [7:0]  b_odata;

    mux_rr_n #(.W(W), .N(4)) u_a (
        .clk_i(clk), .rst_i(rst), .mode_i(a_mode), .sel_i(a_sel),
        .in_valid_i(a_valid), .in_data_i(a_data), .in_ready_o(a_ready),
        .out_valid_o(a_ovalid), .out_data_o(a_odata), .out_ch_o(a_och),
        .out_ready_i(a_oready)
    );

    mux_rr_n #(.W(W), .N(3)) u_b (
        .clk_i(clk), .rst_i(rst), .mode_i(b_mode), .sel_i(b_sel),
        .in_valid_i(b_valid), .in_data_i(b_data), .in_ready_o(b_ready),
        .out_valid_o(b_ovalid), .out_data_o(b_odata), .out_ch_o(b_och),
        .out_ready_i(b_oready)
    );

    int checks = 0;
    int failures = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors pop one expected {data,ch} per word the consumer accepts.
    always @(negedge clk) begin
        if (!rst && a_ovalid === 1'b1 && a_oready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_word: got data 0x%0h ch %0d, expected none", a_odata, a_och);
            end else begin
                logic [9:0] e;
                e = qa.pop_front();
                chk("a_out_data", {24'd0, a_odata}, {24'd0, e[9:2]});
                chk("a_out_ch", {30'd0, a_och}, {30'd0, e[1:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_ovalid === 1'b1 && b_oready) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_word: got data 0x%0h ch %0d, expected none", b_odata, b_och);
            end else begin
                logic [9:0] e;
                e = qb.pop_front();
                chk("b_out_data", {24'd0, b_odata}, {24'd0, e[9:2]});
                chk("b_out_ch", {30'd0, b_och}, {30'd0, e[1:0]});
            end
        end
    end

    task automatic step_a(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                          input logic [3:0] er, input logic push, input logic [7:0] ed, input logic [1:0] ec);
        a_mode = m; a_sel = s; a_valid = v; a_oready = r;
        if (push) qa.push_back({ed, ec});
        @(negedge clk);
        chk("a_in_ready", {28'd0, a_ready}, {28'd0, er});
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic m, input logic [1:0] s, input logic [2:0] v, input logic r,
                          input logic [2:0] er, input logic push, input logic [7:0] ed, input logic [1:0] ec);
        b_mode = m; b_sel = s; b_valid = v; b_oready = r;
        if (push) qb.push_back({ed, ec});
        @(negedge clk);
        chk("b_in_ready", {29'd0, b_ready}, {29'd0, er});
        @(posedge clk);
        #1;
    endtask

    task automatic out_a(input logic v, input logic [7:0] d);
        chk("a_out_valid_now", {31'd0, a_ovalid}, {31'd0, v});
        chk("a_out_data_now", {24'd0, a_odata}, {24'd0, d});
    endtask

    initial begin
        rst = 1'b1;
        a_mode = 1'b1; a_sel = 2'd0; a_valid = 4'hF; a_oready = 1'b1;
        a_data = {8'h33, 8'hA5, 8'h21, 8'h10};
        b_mode = 1'b0; b_sel = 2'd0; b_valid = 3'b000; b_oready = 1'b1;
        b_data = {8'h62, 8'h51, 8'h40};

        @(negedge clk);
        chk("rst_out_valid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_out_data", {24'd0, a_odata}, 32'd0);
        chk("rst_out_ch", {30'd0, a_och}, 32'd0);
        chk("rst_in_ready", {28'd0, a_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fixed select, then round-robin over all four channels
        step_a(1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3);
        // only ch1 and ch3 valid, ptr=0
        step_a(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
        step_a(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3);
        step_a(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
        step_a(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3);
        // ptr=0 -> ch2 leaves ptr=3; then only ch0 valid wraps and ptr becomes 1
        step_a(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        step_a(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
        // idle: empties, data holds, ptr stays at 2
        step_a(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        out_a(1'b0, 8'h21);
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        // backpressure with 0x11 held, then drain and load on one edge
        a_data = {8'h11, 8'hA5, 8'h21, 8'h10};
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd3);
        for (int k = 0; k < 3; k++) begin
            step_a(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
            out_a(1'b1, 8'h11);
        end
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        out_a(1'b1, 8'h10);
        // reset while holding a word discards it and restarts search at ch0
        step_a(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        rst = 1'b1;
        a_oready = 1'b1;
        qa.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, a_ovalid}, 32'd0);
        chk("mid_rst_out_data", {24'd0, a_odata}, 32'd0);
        chk("mid_rst_out_ch", {30'd0, a_och}, 32'd0);
        chk("mid_rst_in_ready", {28'd0, a_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_a(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        step_a(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

        // N=3: fixed select, out-of-range select, then wrap 2 -> 0
        step_b(1'b0, 2'd2, 3'b111, 1'b1, 3'b100, 1'b1, 8'h62, 2'd2);
        step_b(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0);
        chk("b_out_valid_sel3", {31'd0, b_ovalid}, 32'd0);
        chk("b_out_data_sel3", {24'd0, b_odata}, 32'h62);
        step_b(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h40, 2'd0);
        step_b(1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 8'h51, 2'd1);
        step_b(1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1, 8'h62, 2'd2);
        step_b(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h40, 2'd0);
        step_b(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0);
        @(posedge clk);
        #1;

        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
